// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes, registered result and {N,Z,C,V} flags.
// ADD/SUB/logic ops finish on the accept edge; shifts and multiply iterate serially in BUSY.
module seq_alu #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       n,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic [3:0]       cc
);
    localparam int CNTW = CW + 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   w_q, w_d;       // shift operand, or remaining multiplier bits
    logic [2*WIDTH-1:0] mc_q, mc_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic [3:0]         cc_q, cc_d;

    logic [2:0]         cur_op;
    logic [WIDTH-1:0]   sh_in, sh_res;
    logic               sh_bit;
    logic [WIDTH:0]     sum, diff;
    logic [2*WIDTH-1:0] acc_nx;
    logic [CW-1:0]      s;
    logic               load, res_c, res_v;
    logic [WIDTH-1:0]   res;

    // One-bit shifter shared by the accept cycle (operand a) and every BUSY cycle (w_q).
    always_comb begin
        cur_op = (state_q == IDLE) ? n : op_q;
        sh_in  = (state_q == IDLE) ? a : w_q;
        if (cur_op == OP_SHR) begin
            sh_res = {1'b0, sh_in[WIDTH-1:1]};
            sh_bit = sh_in[0];
        end else begin
            sh_res = {sh_in[WIDTH-2:0], 1'b0};
            sh_bit = sh_in[WIDTH-1];
        end
        sum    = {1'b0, a} + {1'b0, b};
        diff   = {1'b0, a} - {1'b0, b};
        acc_nx = acc_q + (w_q[0] ? mc_q : '0);
        s      = b[CW-1:0];
    end

    // NOTE: every signal written here gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        w_d     = w_q;
        mc_d    = mc_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        res     = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = n;
                    state_d = DONE;
                    load    = 1'b1;
                    case (n)
                        OP_ADD: begin
                            res   = sum[WIDTH-1:0];
                            res_c = sum[WIDTH];
                            res_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                        end
                        OP_SUB: begin
                            res   = diff[WIDTH-1:0];
                            res_c = diff[WIDTH];
                            res_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
                        end
                        OP_AND: res = a & b;
                        OP_OR:  res = a | b;
                        OP_XOR: res = a ^ b;
                        OP_SHL, OP_SHR: begin
                            // The first bit moves on the accept edge, so s bits take s edges in total.
                            if (s == '0) begin
                                res = a;
                            end else if (s == CW'(1)) begin
                                res   = sh_res;
                                res_c = sh_bit;
                            end else begin
                                w_d     = sh_res;
                                cnt_d   = {1'b0, s} - CNTW'(1);
                                load    = 1'b0;
                                state_d = BUSY;
                            end
                        end
                        OP_MUL: begin
                            w_d     = b;
                            mc_d    = {{WIDTH{1'b0}}, a};
                            acc_d   = '0;
                            cnt_d   = CNTW'(WIDTH);
                            load    = 1'b0;
                            state_d = BUSY;
                        end
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNTW'(1);
                if (op_q == OP_MUL) begin
                    acc_d = acc_nx;
                    mc_d  = {mc_q[2*WIDTH-2:0], 1'b0};
                    w_d   = {1'b0, w_q[WIDTH-1:1]};
                    res   = acc_nx[WIDTH-1:0];
                    res_c = |acc_nx[2*WIDTH-1:WIDTH];
                end else begin
                    w_d   = sh_res;
                    res   = sh_res;
                    res_c = sh_bit;
                end
                if (cnt_q == CNTW'(1)) begin
                    load    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        r_d  = load ? res : r_q;
        cc_d = load ? {res[WIDTH-1], (res == '0), res_c, res_v} : cc_q;
    end

    // NOTE: state is assigned with <= so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            w_q     <= '0;
            mc_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            r_q     <= '0;
            cc_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            w_q     <= w_d;
            mc_q    <= mc_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            cc_q    <= cc_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && rst_n;
    assign out_valid = (state_q == DONE);
    assign r         = r_q;
    assign cc        = cc_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=8): results, flags, latency, backpressure and reset.
module tb_seq_alu;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a, b;
    logic [2:0] n;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] r;
    logic [3:0] cc;

    int checks = 0;
    int errors = 0;

    seq_alu #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .n(n), .out_valid(out_valid), .out_ready(out_ready),
        .r(r), .cc(cc)
    );

    always #5 clk = ~clk;

    // Issue one op, scramble operands after accept, wait (bounded) for out_valid, then consume it.
    task automatic run_op(input logic [2:0] op, input logic [7:0] aa, input logic [7:0] bb,
                          output int lat, output logic [7:0] rr, output logic [3:0] ccv);
        @(negedge clk);
        in_valid  = 1'b1;
        n         = op;
        a         = aa;
        b         = bb;
        out_ready = 1'b0;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        a        = ~aa;
        b        = ~bb;
        n        = ~op;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        rr        = r;
        ccv       = cc;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic check_op(input string name, input logic [2:0] op, input logic [7:0] aa,
                            input logic [7:0] bb, input logic [7:0] exp_r, input logic [3:0] exp_cc,
                            input int exp_lat);
        int         lat;
        logic [7:0] rr;
        logic [3:0] ccv;
        run_op(op, aa, bb, lat, rr, ccv);
        checks++;
        if (rr !== exp_r) begin
            errors++;
            $display("FAIL %s r: got %h expected %h", name, rr, exp_r);
        end
        checks++;
        if (ccv !== exp_cc) begin
            errors++;
            $display("FAIL %s cc: got %b expected %b", name, ccv, exp_cc);
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = '0; b = '0; n = '0;
        #12;
        checks++;
        if ({out_valid, in_ready, r, cc} !== 14'd0) begin
            errors++;
            $display("FAIL reset outputs: got ov=%b ir=%b r=%h cc=%b expected all 0",
                     out_valid, in_ready, r, cc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset release in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_add_sub();
        check_op("add_ff_01", 3'b000, 8'hFF, 8'h01, 8'h00, 4'b0110, 1);
        check_op("add_7f_01", 3'b000, 8'h7F, 8'h01, 8'h80, 4'b1001, 1);
        check_op("sub_80_01", 3'b001, 8'h80, 8'h01, 8'h7F, 4'b0001, 1);
        check_op("sub_01_02", 3'b001, 8'h01, 8'h02, 8'hFF, 4'b1010, 1);
    endtask

    task automatic test_logic();
        check_op("and", 3'b010, 8'hF0, 8'h0F, 8'h00, 4'b0100, 1);
        check_op("or",  3'b011, 8'hF0, 8'h0F, 8'hFF, 4'b1000, 1);
        check_op("xor", 3'b100, 8'hAA, 8'hFF, 8'h55, 4'b0000, 1);
    endtask

    task automatic test_shift();
        check_op("shl_81_1", 3'b101, 8'h81, 8'h01, 8'h02, 4'b0010, 1);
        check_op("shr_81_7", 3'b110, 8'h81, 8'h07, 8'h01, 4'b0000, 7);
        check_op("shl_5a_0", 3'b101, 8'h5A, 8'hF8, 8'h5A, 4'b0000, 1);
        check_op("shl_c3_3", 3'b101, 8'hC3, 8'h03, 8'h18, 4'b0000, 3);
        check_op("shr_a5_2", 3'b110, 8'hA5, 8'h02, 8'h29, 4'b0000, 2);
    endtask

    task automatic test_mul();
        check_op("mul_10_10", 3'b111, 8'h10, 8'h10, 8'h00, 4'b0110, 9);
        check_op("mul_0f_03", 3'b111, 8'h0F, 8'h03, 8'h2D, 4'b0000, 9);
        check_op("mul_0c_0b", 3'b111, 8'h0C, 8'h0B, 8'h84, 4'b1000, 9);
    endtask

    task automatic test_backpressure();
        int wait_cyc;
        @(negedge clk);
        in_valid = 1'b1; n = 3'b000; a = 8'h12; b = 8'h34; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a = 8'h01; b = 8'h01;          // held request for the next op
        wait_cyc = 0;
        while (!out_valid && wait_cyc < 20) begin
            @(posedge clk);
            @(negedge clk);
            wait_cyc++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({out_valid, in_ready, r, cc} !== {1'b1, 1'b0, 8'h46, 4'b0000}) begin
                errors++;
                $display("FAIL backpressure hold %0d: got ov=%b ir=%b r=%h cc=%b expected ov=1 ir=0 r=46 cc=0000",
                         i, out_valid, in_ready, r, cc);
            end
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready, r} !== {1'b0, 1'b1, 8'h46}) begin
            errors++;
            $display("FAIL backpressure after handshake: got ov=%b ir=%b r=%h expected ov=0 ir=1 r=46",
                     out_valid, in_ready, r);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({out_valid, r, cc} !== {1'b1, 8'h02, 4'b0000}) begin
            errors++;
            $display("FAIL backpressure next op: got ov=%b r=%h cc=%b expected ov=1 r=02 cc=0000",
                     out_valid, r, cc);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        in_valid = 1'b1; n = 3'b000; a = 8'h03; b = 8'h04; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready, r} !== {1'b1, 1'b0, 8'h07}) begin
            errors++;
            $display("FAIL b2b first: got ov=%b ir=%b r=%h expected ov=1 ir=0 r=07", out_valid, in_ready, r);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL b2b gap: got ov=%b ir=%b expected ov=0 ir=1", out_valid, in_ready);
        end
        a = 8'h05; b = 8'h06;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, r} !== {1'b1, 8'h0B}) begin
            errors++;
            $display("FAIL b2b second: got ov=%b r=%h expected ov=1 r=0b", out_valid, r);
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready, r} !== {1'b0, 1'b1, 8'h0B}) begin
            errors++;
            $display("FAIL b2b idle with out_ready: got ov=%b ir=%b r=%h expected ov=0 ir=1 r=0b",
                     out_valid, in_ready, r);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_mul();
        @(negedge clk);
        in_valid = 1'b1; n = 3'b111; a = 8'h0F; b = 8'h03; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, r, cc} !== 14'd0) begin
            errors++;
            $display("FAIL mid-mul reset: got ov=%b ir=%b r=%h cc=%b expected all 0",
                     out_valid, in_ready, r, cc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL mid-mul release: got ov=%b ir=%b expected ov=0 ir=1", out_valid, in_ready);
        end
        check_op("add_after_reset", 3'b000, 8'h7F, 8'h01, 8'h80, 4'b1001, 1);
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_logic();
        test_shift();
        test_mul();
        test_backpressure();
        test_back_to_back();
        test_check_ops_done: begin end
        check_op("sub_prev_clear", 3'b001, 8'h05, 8'h05, 8'h00, 4'b0100, 1);
        test_reset_mid_mul();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
